// File: rtl/multicycle_ctrl.sv
// Main control FSM for the multi-cycle MIPS datapath: sequences fetch, decode,
// execute, memory and writeback, and stalls on the shared memory via mem_ready.
module multicycle_ctrl #(
  parameter logic [5:0] OP_RTYPE = 6'b000000,
  parameter logic [5:0] OP_LW    = 6'b100011,
  parameter logic [5:0] OP_SW    = 6'b101011,
  parameter logic [5:0] OP_BEQ   = 6'b000100,
  parameter logic [5:0] OP_ADDI  = 6'b001000,
  parameter logic [5:0] OP_J     = 6'b000010
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       mem_to_reg,
  output logic       reg_dst,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] pc_source,
  output logic [3:0] state,
  output logic       retire,
  output logic       illegal
);

  // state   | meaning
  // IDLE    | out of reset, no activity
  // FETCH   | read instruction at PC, PC += 4 on mem_ready
  // DECODE  | register read, branch target precompute, dispatch on opcode
  // MEM_ADR | effective address = A + sign-ext imm
  // MEM_RD  | load data read, waits on mem_ready
  // MEM_WB  | MDR -> rt
  // MEM_WR  | store data write, waits on mem_ready
  // EXEC_R  | A funct B
  // R_WB    | ALUOut -> rd
  // BRANCH  | A - B, PC <= target if zero
  // JUMP    | PC <= jump target
  // ADDI_EX | A + sign-ext imm
  // ADDI_WB | ALUOut -> rt
  localparam logic [3:0] ST_IDLE    = 4'd0;
  localparam logic [3:0] ST_FETCH   = 4'd1;
  localparam logic [3:0] ST_DECODE  = 4'd2;
  localparam logic [3:0] ST_MEM_ADR = 4'd3;
  localparam logic [3:0] ST_MEM_RD  = 4'd4;
  localparam logic [3:0] ST_MEM_WB  = 4'd5;
  localparam logic [3:0] ST_MEM_WR  = 4'd6;
  localparam logic [3:0] ST_EXEC_R  = 4'd7;
  localparam logic [3:0] ST_R_WB    = 4'd8;
  localparam logic [3:0] ST_BRANCH  = 4'd9;
  localparam logic [3:0] ST_JUMP    = 4'd10;
  localparam logic [3:0] ST_ADDI_EX = 4'd11;
  localparam logic [3:0] ST_ADDI_WB = 4'd12;

  logic [3:0] state_q;
  logic [3:0] state_d;

  logic op_rtype;
  logic op_lw;
  logic op_sw;
  logic op_beq;
  logic op_addi;
  logic op_j;
  logic op_legal;

  assign op_rtype = (opcode == OP_RTYPE);
  assign op_lw    = (opcode == OP_LW);
  assign op_sw    = (opcode == OP_SW);
  assign op_beq   = (opcode == OP_BEQ);
  assign op_addi  = (opcode == OP_ADDI);
  assign op_j     = (opcode == OP_J);
  assign op_legal = op_rtype | op_lw | op_sw | op_beq | op_addi | op_j;

  // Asynchronous clear drops state to IDLE, so every strobe falls without a clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  assign state = state_q;

  always_comb begin
    state_d = ST_FETCH;
    case (state_q)
      ST_IDLE:    state_d = ST_FETCH;
      ST_FETCH:   state_d = mem_ready ? ST_DECODE : ST_FETCH;
      ST_DECODE: begin
        if (op_lw || op_sw) begin
          state_d = ST_MEM_ADR;
        end else if (op_rtype) begin
          state_d = ST_EXEC_R;
        end else if (op_beq) begin
          state_d = ST_BRANCH;
        end else if (op_j) begin
          state_d = ST_JUMP;
        end else if (op_addi) begin
          state_d = ST_ADDI_EX;
        end else begin
          state_d = ST_FETCH;
        end
      end
      // opcode is held stable after fetch; anything else here is abandoned
      ST_MEM_ADR: begin
        if (op_lw) begin
          state_d = ST_MEM_RD;
        end else if (op_sw) begin
          state_d = ST_MEM_WR;
        end else begin
          state_d = ST_FETCH;
        end
      end
      ST_MEM_RD:  state_d = mem_ready ? ST_MEM_WB : ST_MEM_RD;
      ST_MEM_WB:  state_d = ST_FETCH;
      ST_MEM_WR:  state_d = mem_ready ? ST_FETCH : ST_MEM_WR;
      ST_EXEC_R:  state_d = ST_R_WB;
      ST_R_WB:    state_d = ST_FETCH;
      ST_BRANCH:  state_d = ST_FETCH;
      ST_JUMP:    state_d = ST_FETCH;
      ST_ADDI_EX: state_d = ST_ADDI_WB;
      ST_ADDI_WB: state_d = ST_FETCH;
      default:    state_d = ST_FETCH;
    endcase
  end

  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    mem_to_reg    = 1'b0;
    reg_dst       = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    alu_op        = 2'b00;
    pc_source     = 2'b00;
    retire        = 1'b0;
    illegal       = 1'b0;
    case (state_q)
      ST_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
      end
      ST_DECODE: begin
        alu_src_b = 2'b11;
        illegal   = ~op_legal;
        retire    = ~op_legal;
      end
      ST_MEM_ADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      ST_MEM_RD: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
      end
      ST_MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        retire     = 1'b1;
      end
      ST_MEM_WR: begin
        mem_write = 1'b1;
        i_or_d    = 1'b1;
        retire    = mem_ready;
      end
      ST_EXEC_R: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b10;
      end
      ST_R_WB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
        retire    = 1'b1;
      end
      ST_BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = 2'b01;
        pc_write_cond = 1'b1;
        pc_source     = 2'b01;
        retire        = 1'b1;
      end
      ST_JUMP: begin
        pc_write  = 1'b1;
        pc_source = 2'b10;
        retire    = 1'b1;
      end
      ST_ADDI_EX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      ST_ADDI_WB: begin
        reg_write = 1'b1;
        retire    = 1'b1;
      end
      default: begin
        retire = 1'b0;
      end
    endcase
  end

endmodule
